// File: rtl/i2c_txn_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_scheduler
// Description : Round-robin scheduler sharing one I2C byte controller among
//               NREQ requesters. Latches one request, drives the controller
//               start/addr/rw/wdata, waits out its busy window and returns
//               read data and status to the granted requester only.
//               Optional per-phase timeout: define I2C_TXN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_scheduler #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int TO_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_grant,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              ctl_enable,
    output logic [6:0]        ctl_addr,
    output logic              ctl_rw,
    output logic [7:0]        ctl_wdata,
    input  logic              ctl_busy,
    input  logic [7:0]        ctl_rdata,
    input  logic              ctl_nack
);

    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_J_W   = c_IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [NREQ-1:0]      r_gnt_oh;
    logic [NREQ-1:0]      r_req_grant;
    logic [NREQ-1:0]      r_rsp_valid;
    logic [7:0]           r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 r_ctl_enable;
    logic [6:0]           r_ctl_addr;
    logic                 r_ctl_rw;
    logic [7:0]           r_ctl_wdata;

    logic                 w_any;
    logic [c_IDX_W-1:0]   w_pick;
    logic [NREQ-1:0]      w_pick_oh;
    logic [c_IDX_W-1:0]   w_rr_next;

`ifdef I2C_TXN_TIMEOUT_EN
    logic [TO_W-1:0]      r_to_cnt;
    logic                 w_to_hit;
    assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC));
`else
    // Timeout parameters have no effect in this build.
    logic                 w_unused_cfg;
    assign w_unused_cfg = ^{32'(TIMEOUT_CYC), 32'(TO_W)};
`endif

    // Round-robin pick: first valid requester scanning upward from rr_ptr, wrapping.
    always_comb begin
        logic [c_J_W-1:0]   j;
        logic [c_IDX_W-1:0] idx;
        w_any  = 1'b0;
        w_pick = '0;
        j      = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, r_rr_ptr} + c_J_W'(k);
            if (j >= c_J_W'(NREQ)) begin
                j = j - c_J_W'(NREQ);
            end
            idx = j[c_IDX_W-1:0];
            if (!w_any && req_valid[idx]) begin
                w_any  = 1'b1;
                w_pick = idx;
            end
        end
    end

    assign w_pick_oh = NREQ'(1) << w_pick;
    assign w_rr_next = (w_pick == c_IDX_W'(NREQ - 1)) ? '0 : w_pick + 1'b1;

    // Sequencing FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_gnt_oh     <= '0;
            r_req_grant  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_ctl_enable <= 1'b0;
            r_ctl_addr   <= '0;
            r_ctl_rw     <= 1'b0;
            r_ctl_wdata  <= '0;
`ifdef I2C_TXN_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_req_grant <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_req_grant  <= w_pick_oh;
                        r_gnt_oh     <= w_pick_oh;
                        r_ctl_addr   <= req_addr[7*int'(w_pick) +: 7];
                        r_ctl_rw     <= req_rw[w_pick];
                        r_ctl_wdata  <= req_wdata[8*int'(w_pick) +: 8];
                        r_ctl_enable <= 1'b1;
                        r_rr_ptr     <= w_rr_next;
                        r_state      <= S_START;
`ifdef I2C_TXN_TIMEOUT_EN
                        r_to_cnt     <= '0;
`endif
                    end
                end
                S_START: begin
                    if (ctl_busy) begin
                        r_ctl_enable <= 1'b0;
                        r_state      <= S_RUN;
`ifdef I2C_TXN_TIMEOUT_EN
                        r_to_cnt     <= '0;
                    end else if (w_to_hit) begin
                        r_ctl_enable <= 1'b0;
                        r_rsp_rdata  <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= r_gnt_oh;
                        r_state      <= S_RESP;
                    end else begin
                        r_to_cnt     <= r_to_cnt + 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    if (!ctl_busy) begin
                        // Writes return zero so stale bus data never leaks out.
                        r_rsp_rdata <= r_ctl_rw ? ctl_rdata : 8'h00;
                        r_rsp_err   <= ctl_nack;
                        r_rsp_valid <= r_gnt_oh;
                        r_state     <= S_RESP;
`ifdef I2C_TXN_TIMEOUT_EN
                    end else if (w_to_hit) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_gnt_oh;
                        r_state     <= S_RESP;
                    end else begin
                        r_to_cnt    <= r_to_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_grant  = r_req_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign ctl_enable = r_ctl_enable;
    assign ctl_addr   = r_ctl_addr;
    assign ctl_rw     = r_ctl_rw;
    assign ctl_wdata  = r_ctl_wdata;

endmodule
`default_nettype wire
